// File: rtl/game_pkg.sv
// Shared game constants: playfield size, state encoding and HUD field widths.
// Imported by the collision controller and the car/frog sprite controllers.
package game_pkg;

  localparam int c_GAME_WIDTH  = 640;
  localparam int c_GAME_HEIGHT = 480;

  localparam int LIVES_W = 3;
  localparam int SCORE_W = 8;
  localparam int OVL_W   = 8;
  localparam int FROG_Y_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_HIT       = 3'd2,
    ST_WIN       = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

endpackage

// File: rtl/overlap_accum.sv
// Per-frame frog/car overlap pixel counter with a frame-boundary reload.
// On the i_Frame_Start cycle o_Frame_Total holds the finished frame's total.
module overlap_accum
  import game_pkg::*;
#(
  parameter int c_NUM_CARS = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Enable,
  input  logic                  i_Frame_Start,
  input  logic                  i_Draw_Frog,
  input  logic [c_NUM_CARS-1:0] i_Draw_Car,
  output logic [OVL_W-1:0]      o_Frame_Total
);

  logic             overlap;
  logic [OVL_W-1:0] cnt;

  function automatic logic [OVL_W-1:0] sat_inc(input logic [OVL_W-1:0] v);
    return (v == {OVL_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign overlap = i_Draw_Frog & (|i_Draw_Car);

  // A pixel on the frame-start cycle already belongs to the new frame.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt <= '0;
    end else if (!i_Enable) begin
      cnt <= '0;
    end else if (i_Frame_Start) begin
      cnt <= {{(OVL_W-1){1'b0}}, overlap};
    end else if (overlap) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign o_Frame_Total = cnt;

endmodule

// File: rtl/frog_collision_ctrl.sv
// Game-state controller: frame-based frog/car hit detection, lives, score and
// respawn/win pauses. o_Game_Active gates the car controllers.
module frog_collision_ctrl
  import game_pkg::*;
#(
  parameter int c_NUM_CARS       = 4,
  parameter int c_LIVES          = 3,
  parameter int c_HIT_PIXELS     = 4,
  parameter int c_RESPAWN_FRAMES = 60,
  parameter int c_WIN_FRAMES     = 90,
  parameter int c_GOAL_Y         = 0
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Start,
  input  logic                  i_Frame_Start,
  input  logic                  i_Draw_Frog,
  input  logic [c_NUM_CARS-1:0] i_Draw_Car,
  input  logic [FROG_Y_W-1:0]   i_Frog_Y,
  output logic                  o_Game_Active,
  output logic                  o_Frog_Reset,
  output logic                  o_Hit,
  output logic [LIVES_W-1:0]    o_Lives,
  output logic [SCORE_W-1:0]    o_Score,
  output logic [2:0]            o_State
);

  localparam int c_TMR_MAX = (c_RESPAWN_FRAMES > c_WIN_FRAMES) ? c_RESPAWN_FRAMES : c_WIN_FRAMES;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

  localparam logic [c_TMR_W-1:0]  c_RESPAWN_LAST = c_TMR_W'(c_RESPAWN_FRAMES - 1);
  localparam logic [c_TMR_W-1:0]  c_WIN_LAST     = c_TMR_W'(c_WIN_FRAMES - 1);
  localparam logic [LIVES_W-1:0]  c_LIVES_INIT   = LIVES_W'(c_LIVES);
  localparam logic [OVL_W-1:0]    c_HIT_THR      = OVL_W'(c_HIT_PIXELS);
  localparam logic [FROG_Y_W-1:0] c_GOAL         = FROG_Y_W'(c_GOAL_Y);

  game_state_t          state;
  logic [c_TMR_W-1:0]   frame_cnt;
  logic [OVL_W-1:0]     frame_total;
  logic                 frame_hit;
  logic                 frame_goal;

  function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [LIVES_W-1:0] sat_dec_lives(input logic [LIVES_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  overlap_accum #(
    .c_NUM_CARS(c_NUM_CARS)
  ) u_overlap_accum (
    .i_Clk        (i_Clk),
    .i_Rst_n      (i_Rst_n),
    .i_Enable     (state == ST_PLAYING),
    .i_Frame_Start(i_Frame_Start),
    .i_Draw_Frog  (i_Draw_Frog),
    .i_Draw_Car   (i_Draw_Car),
    .o_Frame_Total(frame_total)
  );

  assign frame_hit  = (frame_total >= c_HIT_THR);
  assign frame_goal = (i_Frog_Y <= c_GOAL);

  // Hit outranks a crossing seen in the same frame.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state         <= ST_IDLE;
      o_Lives       <= c_LIVES_INIT;
      o_Score       <= '0;
      frame_cnt     <= '0;
      o_Hit         <= 1'b0;
      o_Frog_Reset  <= 1'b0;
      o_Game_Active <= 1'b0;
    end else begin
      o_Hit         <= 1'b0;
      o_Frog_Reset  <= 1'b0;
      o_Game_Active <= (state == ST_PLAYING);
      case (state)
        ST_IDLE, ST_GAME_OVER: begin
          if (i_Start) begin
            state        <= ST_PLAYING;
            o_Lives      <= c_LIVES_INIT;
            o_Score      <= '0;
            o_Frog_Reset <= 1'b1;
          end
        end
        ST_PLAYING: begin
          if (i_Frame_Start) begin
            if (frame_hit) begin
              state     <= ST_HIT;
              o_Hit     <= 1'b1;
              o_Lives   <= sat_dec_lives(o_Lives);
              frame_cnt <= '0;
            end else if (frame_goal) begin
              state     <= ST_WIN;
              o_Score   <= sat_inc_score(o_Score);
              frame_cnt <= '0;
            end
          end
        end
        ST_HIT: begin
          if (i_Frame_Start) begin
            if (frame_cnt == c_RESPAWN_LAST) begin
              if (o_Lives == '0) begin
                state <= ST_GAME_OVER;
              end else begin
                state        <= ST_PLAYING;
                o_Frog_Reset <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        ST_WIN: begin
          if (i_Frame_Start) begin
            if (frame_cnt == c_WIN_LAST) begin
              state        <= ST_PLAYING;
              o_Frog_Reset <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_State = state;

endmodule

// File: tb/tb_frog_collision_ctrl.sv
// Directed bench for frog_collision_ctrl with default parameters.
module tb_frog_collision_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_Start = 1'b0;
  logic       i_Frame_Start = 1'b0;
  logic       i_Draw_Frog = 1'b0;
  logic [3:0] i_Draw_Car = 4'd0;
  logic [9:0] i_Frog_Y = 10'd400;
  logic       o_Game_Active;
  logic       o_Frog_Reset;
  logic       o_Hit;
  logic [2:0] o_Lives;
  logic [7:0] o_Score;
  logic [2:0] o_State;

  int checks = 0;
  int errors = 0;

  frog_collision_ctrl dut (
    .i_Clk        (i_Clk),
    .i_Rst_n      (i_Rst_n),
    .i_Start      (i_Start),
    .i_Frame_Start(i_Frame_Start),
    .i_Draw_Frog  (i_Draw_Frog),
    .i_Draw_Car   (i_Draw_Car),
    .i_Frog_Y     (i_Frog_Y),
    .o_Game_Active(o_Game_Active),
    .o_Frog_Reset (o_Frog_Reset),
    .o_Hit        (o_Hit),
    .o_Lives      (o_Lives),
    .o_Score      (o_Score),
    .o_State      (o_State)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) begin
      i_Draw_Frog = 1'b1;
      i_Draw_Car  = 4'(1 << (i % 4));
      tick();
    end
    i_Draw_Frog = 1'b0;
    i_Draw_Car  = 4'd0;
  endtask

  task automatic frame();
    i_Frame_Start = 1'b1;
    tick();
    i_Frame_Start = 1'b0;
  endtask

  task automatic frame_gap(input int n);
    for (int i = 0; i < n; i++) begin
      frame();
      tick();
    end
  endtask

  task automatic test_reset();
    i_Rst_n = 1'b0;
    tick(); tick();
    checks++; if (o_State !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_State); end
    checks++; if (o_Lives !== 3'd3) begin errors++; $display("FAIL reset_lives: got %0d want 3", o_Lives); end
    checks++; if (o_Score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", o_Score); end
    checks++; if ({o_Game_Active, o_Frog_Reset, o_Hit} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b want 000", {o_Game_Active, o_Frog_Reset, o_Hit}); end
    i_Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_start();
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    checks++; if (o_State !== 3'd1) begin errors++; $display("FAIL start_state: got %0d want 1", o_State); end
    checks++; if (o_Frog_Reset !== 1'b1) begin errors++; $display("FAIL start_frog_reset: got %b want 1", o_Frog_Reset); end
    checks++; if (o_Lives !== 3'd3 || o_Score !== 8'd0) begin
      errors++; $display("FAIL start_hud: got lives %0d score %0d want 3 0", o_Lives, o_Score); end
    checks++; if (o_Game_Active !== 1'b0) begin errors++; $display("FAIL start_active_early: got %b want 0", o_Game_Active); end
    tick();
    checks++; if (o_Frog_Reset !== 1'b0) begin errors++; $display("FAIL start_reset_width: got %b want 0", o_Frog_Reset); end
    checks++; if (o_Game_Active !== 1'b1) begin errors++; $display("FAIL start_active: got %b want 1", o_Game_Active); end
  endtask

  task automatic test_below_threshold();
    i_Frog_Y = 10'd400;
    i_Draw_Frog = 1'b1; tick();
    i_Draw_Frog = 1'b0; i_Draw_Car = 4'b1010; tick();
    i_Draw_Car = 4'd0;
    pixels(3);
    frame();
    checks++; if (o_State !== 3'd1 || o_Hit !== 1'b0) begin
      errors++; $display("FAIL thr3: got state %0d hit %b want 1 0", o_State, o_Hit); end
    checks++; if (o_Lives !== 3'd3) begin errors++; $display("FAIL thr3_lives: got %0d want 3", o_Lives); end
    tick();
  endtask

  task automatic test_boundary_hit();
    pixels(3);
    i_Draw_Frog = 1'b1; i_Draw_Car = 4'b0100;
    frame();
    i_Draw_Frog = 1'b0; i_Draw_Car = 4'd0;
    checks++; if (o_State !== 3'd1) begin errors++; $display("FAIL boundary_no_hit: got state %0d want 1", o_State); end
    pixels(3);
    frame();
    checks++; if (o_State !== 3'd2) begin errors++; $display("FAIL hit_state: got %0d want 2", o_State); end
    checks++; if (o_Hit !== 1'b1) begin errors++; $display("FAIL hit_pulse: got %b want 1", o_Hit); end
    checks++; if (o_Lives !== 3'd2) begin errors++; $display("FAIL hit_lives: got %0d want 2", o_Lives); end
    tick();
    checks++; if (o_Hit !== 1'b0) begin errors++; $display("FAIL hit_width: got %b want 0", o_Hit); end
    checks++; if (o_Game_Active !== 1'b0) begin errors++; $display("FAIL hit_inactive: got %b want 0", o_Game_Active); end
  endtask

  task automatic test_respawn();
    frame_gap(59);
    checks++; if (o_State !== 3'd2) begin errors++; $display("FAIL respawn_59: got state %0d want 2", o_State); end
    frame();
    checks++; if (o_State !== 3'd1) begin errors++; $display("FAIL respawn_60: got state %0d want 1", o_State); end
    checks++; if (o_Frog_Reset !== 1'b1) begin errors++; $display("FAIL respawn_reset: got %b want 1", o_Frog_Reset); end
    tick();
    checks++; if (o_Frog_Reset !== 1'b0) begin errors++; $display("FAIL respawn_reset_width: got %b want 0", o_Frog_Reset); end
  endtask

  task automatic test_hit_priority();
    i_Frog_Y = 10'd0;
    pixels(10);
    frame();
    checks++; if (o_State !== 3'd2) begin errors++; $display("FAIL prio_state: got %0d want 2", o_State); end
    checks++; if (o_Score !== 8'd0 || o_Lives !== 3'd1) begin
      errors++; $display("FAIL prio_hud: got score %0d lives %0d want 0 1", o_Score, o_Lives); end
    tick();
    i_Frog_Y = 10'd400;
    frame_gap(60);
    checks++; if (o_State !== 3'd1) begin errors++; $display("FAIL prio_resume: got state %0d want 1", o_State); end
  endtask

  task automatic test_win();
    i_Frog_Y = 10'd0;
    frame();
    checks++; if (o_State !== 3'd3 || o_Score !== 8'd1) begin
      errors++; $display("FAIL win_entry: got state %0d score %0d want 3 1", o_State, o_Score); end
    tick();
    i_Frog_Y = 10'd400;
    frame_gap(89);
    checks++; if (o_State !== 3'd3) begin errors++; $display("FAIL win_89: got state %0d want 3", o_State); end
    frame();
    checks++; if (o_State !== 3'd1 || o_Frog_Reset !== 1'b1) begin
      errors++; $display("FAIL win_90: got state %0d frog_reset %b want 1 1", o_State, o_Frog_Reset); end
    tick();
  endtask

  task automatic test_score_saturation();
    for (int w = 0; w < 254; w++) begin
      i_Frog_Y = 10'd0;
      frame();
      tick();
      i_Frog_Y = 10'd400;
      frame_gap(90);
    end
    checks++; if (o_Score !== 8'd255 || o_State !== 3'd1) begin
      errors++; $display("FAIL score_255: got score %0d state %0d want 255 1", o_Score, o_State); end
    i_Frog_Y = 10'd0;
    frame();
    checks++; if (o_Score !== 8'd255 || o_State !== 3'd3) begin
      errors++; $display("FAIL score_sat: got score %0d state %0d want 255 3", o_Score, o_State); end
    tick();
    i_Frog_Y = 10'd400;
    frame_gap(90);
  endtask

  task automatic test_game_over();
    int fr = 0;
    pixels(4);
    frame();
    checks++; if (o_State !== 3'd2 || o_Lives !== 3'd0) begin
      errors++; $display("FAIL last_hit: got state %0d lives %0d want 2 0", o_State, o_Lives); end
    tick();
    for (int i = 0; i < 60; i++) begin
      frame();
      if (o_Frog_Reset) fr++;
      tick();
      if (o_Frog_Reset) fr++;
    end
    checks++; if (o_State !== 3'd4) begin errors++; $display("FAIL game_over_state: got %0d want 4", o_State); end
    checks++; if (fr !== 0) begin errors++; $display("FAIL game_over_no_reset: got %0d pulses want 0", fr); end
    frame_gap(3);
    checks++; if (o_State !== 3'd4) begin errors++; $display("FAIL game_over_hold: got %0d want 4", o_State); end
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    checks++; if (o_State !== 3'd1 || o_Frog_Reset !== 1'b1) begin
      errors++; $display("FAIL restart: got state %0d frog_reset %b want 1 1", o_State, o_Frog_Reset); end
    checks++; if (o_Lives !== 3'd3 || o_Score !== 8'd0) begin
      errors++; $display("FAIL restart_hud: got lives %0d score %0d want 3 0", o_Lives, o_Score); end
    tick();
  endtask

  task automatic test_reset_mid_hit();
    pixels(4);
    frame();
    checks++; if (o_Hit !== 1'b1 || o_Lives !== 3'd2) begin
      errors++; $display("FAIL pre_reset_hit: got hit %b lives %0d want 1 2", o_Hit, o_Lives); end
    i_Rst_n = 1'b0;
    #1;
    checks++; if (o_State !== 3'd0 || o_Lives !== 3'd3) begin
      errors++; $display("FAIL async_reset: got state %0d lives %0d want 0 3", o_State, o_Lives); end
    checks++; if ({o_Game_Active, o_Frog_Reset, o_Hit} !== 3'b000) begin
      errors++; $display("FAIL async_reset_pulses: got %b want 000", {o_Game_Active, o_Frog_Reset, o_Hit}); end
    tick();
    i_Rst_n = 1'b1;
    tick();
    checks++; if (o_State !== 3'd0 || o_Frog_Reset !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got state %0d frog_reset %b want 0 0", o_State, o_Frog_Reset); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_below_threshold();
    test_boundary_hit();
    test_respawn();
    test_hit_priority();
    test_win();
    test_score_saturation();
    test_game_over();
    test_reset_mid_hit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
